// File: rtl/core_id_ex_stage.sv
// ID/EX pipeline register of the Selen core: captures the decoded instruction,
// forwards results from MEM/WB into the ALU operands and inserts load-use bubbles.
module core_id_ex_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_vld,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_src1_pc_sel,
  input  logic            id_src2_imm_sel,
  input  logic [3:0]      id_alu_op,
  input  logic [2:0]      id_brnch_cnd,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic            id_rd_we,
  input  logic            id_mem_rd,
  input  logic            id_mem_wr,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic            mem_rd_we,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic            wb_rd_we,
  input  logic [XLEN-1:0] wb_result,
  input  logic            flush,
  input  logic            ext_stall,
  output logic            id_stall,
  output logic            ex_vld,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_src1,
  output logic [XLEN-1:0] ex_src2,
  output logic [XLEN-1:0] ex_store_data,
  output logic [3:0]      ex_alu_op,
  output logic [2:0]      ex_brnch_cnd,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic            ex_rd_we,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr
);

  logic [RA_W-1:0] ex_rs1_addr, ex_rs2_addr;
  logic [XLEN-1:0] ex_rs1_data, ex_rs2_data;
  logic            ex_src1_pc_sel, ex_src2_imm_sel;
  logic            lu;
  logic [XLEN-1:0] cap_rs1, cap_rs2, fwd_rs1, fwd_rs2;

  always_comb begin
    lu = ex_vld & ex_mem_rd & (ex_rd_addr != '0) & id_vld &
         ((id_rs1_addr == ex_rd_addr) | (id_rs2_addr == ex_rd_addr));
    id_stall = ext_stall | (lu & ~flush);
  end

  // The regfile is not write-through, so a same-cycle WB write is bypassed on capture.
  always_comb begin
    cap_rs1 = id_rs1_data;
    cap_rs2 = id_rs2_data;
    if (wb_rd_we && (wb_rd_addr != '0) && (wb_rd_addr == id_rs1_addr)) cap_rs1 = wb_result;
    if (wb_rd_we && (wb_rd_addr != '0) && (wb_rd_addr == id_rs2_addr)) cap_rs2 = wb_result;
  end

  always_comb begin
    fwd_rs1 = ex_rs1_data;
    fwd_rs2 = ex_rs2_data;
    if (mem_rd_we && (mem_rd_addr != '0) && (mem_rd_addr == ex_rs1_addr))
      fwd_rs1 = mem_result;
    else if (wb_rd_we && (wb_rd_addr != '0) && (wb_rd_addr == ex_rs1_addr))
      fwd_rs1 = wb_result;
    if (mem_rd_we && (mem_rd_addr != '0) && (mem_rd_addr == ex_rs2_addr))
      fwd_rs2 = mem_result;
    else if (wb_rd_we && (wb_rd_addr != '0) && (wb_rd_addr == ex_rs2_addr))
      fwd_rs2 = wb_result;
  end

  always_comb begin
    ex_src1       = ex_src1_pc_sel  ? ex_pc  : fwd_rs1;
    ex_src2       = ex_src2_imm_sel ? ex_imm : fwd_rs2;
    ex_store_data = fwd_rs2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_vld          <= 1'b0;
      ex_pc           <= '0;
      ex_imm          <= '0;
      ex_rs1_addr     <= '0;
      ex_rs2_addr     <= '0;
      ex_rs1_data     <= '0;
      ex_rs2_data     <= '0;
      ex_src1_pc_sel  <= 1'b0;
      ex_src2_imm_sel <= 1'b0;
      ex_alu_op       <= '0;
      ex_brnch_cnd    <= '0;
      ex_rd_addr      <= '0;
      ex_rd_we        <= 1'b0;
      ex_mem_rd       <= 1'b0;
      ex_mem_wr       <= 1'b0;
    end else if (ext_stall) begin
      // Held instruction latches forwarded operands so they survive producer retirement.
      ex_rs1_data <= fwd_rs1;
      ex_rs2_data <= fwd_rs2;
    end else if (flush || lu) begin
      ex_vld       <= 1'b0;
      ex_brnch_cnd <= '0;
      ex_rd_we     <= 1'b0;
      ex_mem_rd    <= 1'b0;
      ex_mem_wr    <= 1'b0;
    end else begin
      ex_vld          <= id_vld;
      ex_pc           <= id_pc;
      ex_imm          <= id_imm;
      ex_rs1_addr     <= id_rs1_addr;
      ex_rs2_addr     <= id_rs2_addr;
      ex_rs1_data     <= cap_rs1;
      ex_rs2_data     <= cap_rs2;
      ex_src1_pc_sel  <= id_src1_pc_sel;
      ex_src2_imm_sel <= id_src2_imm_sel;
      ex_alu_op       <= id_alu_op;
      ex_rd_addr      <= id_rd_addr;
      ex_brnch_cnd    <= id_vld ? id_brnch_cnd : '0;
      ex_rd_we        <= id_vld & id_rd_we;
      ex_mem_rd       <= id_vld & id_mem_rd;
      ex_mem_wr       <= id_vld & id_mem_wr;
    end
  end

endmodule
